// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one i2c_controller among NREQ single-byte requesters.
// Optional watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module i2c_txn_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [7*NREQ-1:0]         req_addr,
  input  logic [8*NREQ-1:0]         req_data,
  input  logic [NREQ-1:0]           req_rw,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [7:0]                rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic [6:0]                m_addr,
  output logic [7:0]                m_data_in,
  output logic                      m_rw,
  output logic                      m_enable,
  input  logic [7:0]                m_data_out,
  input  logic                      m_ready
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

  state_t          r_state;
  logic            r_rdy_s1, r_rdy_s2;
  logic [NREQ-1:0] r_req_ready, r_rsp_valid;
  logic [7:0]      r_rsp_data;
  logic [IW-1:0]   r_grant, r_last;
  logic [6:0]      r_m_addr;
  logic [7:0]      r_m_data_in;
  logic            r_m_rw, r_m_enable;

  logic            w_ready_s, w_found;
  logic [IW-1:0]   w_start, w_win;
  logic [6:0]      w_sel_addr;
  logic [7:0]      w_sel_data;
  logic            w_sel_rw;

  // Synchronizer resets to 1 so an idle controller is assumed out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy_s1 <= 1'b1;
      r_rdy_s2 <= 1'b1;
    end else begin
      r_rdy_s1 <= m_ready;
      r_rdy_s2 <= r_rdy_s1;
    end
  end
  assign w_ready_s = r_rdy_s2;

  // r_last resets to NREQ-1 so the first search starts at requester 0.
  assign w_start = (r_last == IW'(NREQ-1)) ? '0 : r_last + 1'b1;

  always_comb begin
    logic [IW-1:0] idx;
    idx     = '0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(w_start) + k) % NREQ);
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_rw   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IW'(i)) begin
        w_sel_addr = req_addr[i*7 +: 7];
        w_sel_data = req_data[i*8 +: 8];
        w_sel_rw   = req_rw[i];
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = 13;
  logic [CW-1:0] r_cnt;
  logic          r_rsp_err;
  logic          w_tmo;

  // Held at zero in IDLE, so it is zero on ISSUE entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      r_cnt <= '0;
    else if (r_state == S_IDLE)                    r_cnt <= '0;
    else if (r_state == S_ISSUE || r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
  end
  assign w_tmo   = (r_cnt == CW'(TIMEOUT-1));
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_grant     <= '0;
      r_last      <= IW'(NREQ-1);
      r_m_addr    <= '0;
      r_m_data_in <= '0;
      r_m_rw      <= 1'b0;
      r_m_enable  <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found && w_ready_s) begin
            r_m_addr             <= w_sel_addr;
            r_m_data_in          <= w_sel_data;
            r_m_rw               <= w_sel_rw;
            r_grant              <= w_win;
            r_req_ready[w_win]   <= 1'b1;
            r_m_enable           <= 1'b1;
            r_state              <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef I2C_ARB_TIMEOUT_EN
          if (w_tmo) begin
            r_m_enable           <= 1'b0;
            r_rsp_err            <= 1'b1;
            r_rsp_valid[r_grant] <= 1'b1;
            r_state              <= S_RESPOND;
          end else
`endif
          if (!w_ready_s) begin
            r_m_enable <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
`ifdef I2C_ARB_TIMEOUT_EN
          if (w_tmo) begin
            r_rsp_err            <= 1'b1;
            r_rsp_valid[r_grant] <= 1'b1;
            r_state              <= S_RESPOND;
          end else
`endif
          if (w_ready_s) begin
            r_rsp_data           <= m_data_out;
            r_rsp_valid[r_grant] <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
            r_rsp_err            <= 1'b0;
`endif
            r_state              <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          r_last  <= r_grant;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != S_IDLE);
  assign grant_id  = r_grant;
  assign m_addr    = r_m_addr;
  assign m_data_in = r_m_data_in;
  assign m_rw      = r_m_rw;
  assign m_enable  = r_m_enable;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter with a behavioural controller stub and a manual ready override.
`timescale 1ns/1ps
module tb_i2c_txn_arbiter;
  localparam int NREQ = 4;
  localparam logic [7:0] SLV_BYTE = 8'h5C;
  localparam logic [7:0] WR_GARB  = 8'h3C;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid, req_ready, req_rw, rsp_valid;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_data;
  logic [7:0]      rsp_data, m_data_in, m_data_out;
  logic            rsp_err, busy, m_rw, m_enable, m_ready;
  logic [1:0]      grant_id;
  logic [6:0]      m_addr;

  logic            man_mode, man_ready;
  logic            st_ready;
  logic [2:0]      st_cnt;
  logic [7:0]      st_dout, st_wdata;
  logic [6:0]      st_addr;

  int checks = 0;
  int errors = 0;

  i2c_txn_arbiter #(.NREQ(NREQ), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_rw(req_rw),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .grant_id(grant_id),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_rw(m_rw), .m_enable(m_enable),
    .m_data_out(m_data_out), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // Controller stub: drops ready one cycle after seeing enable, busy for 6 cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_ready <= 1'b1; st_cnt <= '0; st_dout <= '0; st_addr <= '0; st_wdata <= '0;
    end else if (st_cnt != 3'd0) begin
      st_cnt <= st_cnt - 3'd1;
      if (st_cnt == 3'd1) begin
        st_ready <= 1'b1;
        st_dout  <= m_rw ? SLV_BYTE : WR_GARB;
      end
    end else if (m_enable && st_ready) begin
      st_ready <= 1'b0; st_cnt <= 3'd6; st_addr <= m_addr; st_wdata <= m_data_in;
    end
  end
  assign m_ready    = man_mode ? man_ready : st_ready;
  assign m_data_out = st_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp);
    int n = 0;
    while (req_ready == '0 && n < 300) begin @(negedge clk); n++; end
    check({tag, "/grant"}, 32'(req_ready), 32'(exp));
  endtask

  task automatic wait_rsp(input string tag, input logic [3:0] exp, input logic exp_err,
                          input logic chk_data, input logic [7:0] exp_data);
    int n = 0;
    while (rsp_valid == '0 && n < 300) begin @(negedge clk); n++; end
    check({tag, "/rsp"}, 32'(rsp_valid), 32'(exp));
    check({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
    if (chk_data) check({tag, "/data"}, 32'(rsp_data), 32'(exp_data));
    @(negedge clk);
    check({tag, "/pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    req_valid = '0; req_addr = '0; req_data = '0; req_rw = '0;
    man_mode = 1'b0; man_ready = 1'b1; rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst/req_ready", 32'(req_ready), 32'd0);
    check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/grant_id", 32'(grant_id), 32'd0);
    check("rst/m_enable", 32'(m_enable), 32'd0);
    check("rst/m_bus", 32'({m_addr, m_data_in, m_rw}), 32'd0);
    check("rst/rsp", 32'({rsp_data, rsp_err}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single write from requester 0
    req_addr[0 +: 7] = 7'h2A; req_data[0 +: 8] = 8'hAA; req_rw[0] = 1'b0; req_valid[0] = 1'b1;
    @(negedge clk);
    check("wr/req_ready", 32'(req_ready), 32'h1);
    check("wr/m_enable", 32'(m_enable), 32'd1);
    check("wr/m_addr", 32'(m_addr), 32'h2A);
    check("wr/m_data_in", 32'(m_data_in), 32'hAA);
    check("wr/m_rw", 32'(m_rw), 32'd0);
    check("wr/busy", 32'(busy), 32'd1);
    req_valid[0] = 1'b0;
    n = 1;
    while (m_enable && n < 50) begin @(negedge clk); n++; end
    check("wr/en_width", 32'(n - 1), 32'd4);
    check("wr/stub_addr", 32'(st_addr), 32'h2A);
    check("wr/stub_data", 32'(st_wdata), 32'hAA);
    wait_rsp("wr", 4'b0001, 1'b0, 1'b1, WR_GARB);
    check("wr/m_addr_hold", 32'(m_addr), 32'h2A);

    // Read from requester 2
    req_addr[14 +: 7] = 7'h2A; req_rw[2] = 1'b1; req_valid[2] = 1'b1;
    wait_grant("rd", 4'b0100);
    check("rd/grant_id", 32'(grant_id), 32'd2);
    check("rd/m_rw", 32'(m_rw), 32'd1);
    req_valid[2] = 1'b0;
    wait_rsp("rd", 4'b0100, 1'b0, 1'b1, SLV_BYTE);

    // Controller never drops ready: watchdog or indefinite wait
    man_mode = 1'b1; man_ready = 1'b1; req_valid[0] = 1'b1;
    wait_grant("to", 4'b0001);
    req_valid[0] = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    n = 0;
    while (rsp_valid == '0 && n < 200) begin @(negedge clk); n++; end
    check("to/latency", 32'(n), 32'd64);
    check("to/rsp_valid", 32'(rsp_valid), 32'h1);
    check("to/rsp_err", 32'(rsp_err), 32'd1);
    check("to/rsp_data", 32'(rsp_data), 32'(SLV_BYTE));
    check("to/m_enable", 32'(m_enable), 32'd0);
`else
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!busy || !m_enable || rsp_valid != '0) bad++;
    end
    check("to/hold", 32'(bad), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("to/async_en", 32'(m_enable), 32'd0);
    check("to/async_busy", 32'(busy), 32'd0);
`endif

    // Contention at reset exit: 0,1,3 then re-asserted 0 after 3
    @(negedge clk);
    rst = 1'b0; man_mode = 1'b0; req_rw = '0;
    req_addr[0 +: 7] = 7'h10; req_addr[7 +: 7] = 7'h11; req_addr[21 +: 7] = 7'h13;
    req_valid = 4'b1011;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_grant("c0", 4'b0001);
    check("c0/m_addr", 32'(m_addr), 32'h10);
    req_valid[0] = 1'b0;
    wait_rsp("c0", 4'b0001, 1'b0, 1'b0, 8'h00);
    req_valid[0] = 1'b1;
    wait_grant("c1", 4'b0010);
    check("c1/m_addr", 32'(m_addr), 32'h11);
    req_valid[1] = 1'b0;
    wait_rsp("c1", 4'b0010, 1'b0, 1'b0, 8'h00);
    wait_grant("c3", 4'b1000);
    req_valid[3] = 1'b0;
    wait_rsp("c3", 4'b1000, 1'b0, 1'b0, 8'h00);
    wait_grant("c0b", 4'b0001);
    req_valid[0] = 1'b0;
    wait_rsp("c0b", 4'b0001, 1'b0, 1'b0, 8'h00);

    // Busy controller holds off the grant; then reset in WAIT_DONE
    man_mode = 1'b1; man_ready = 1'b0;
    repeat (3) @(negedge clk);
    req_valid[1] = 1'b1;
    bad = 0;
    repeat (6) begin @(negedge clk); if (req_ready != '0) bad++; end
    check("bz/no_grant", 32'(bad), 32'd0);
    man_ready = 1'b1;
    @(negedge clk); check("bz/rise+1", 32'(req_ready), 32'd0);
    @(negedge clk); check("bz/rise+2", 32'(req_ready), 32'd0);
    @(negedge clk); check("bz/rise+3", 32'(req_ready), 32'h2);
    req_valid[1] = 1'b0;
    check("bz/m_enable", 32'(m_enable), 32'd1);
    man_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("bz/en_drop", 32'(m_enable), 32'd0);
    check("bz/busy_wait", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rs/busy", 32'(busy), 32'd0);
    check("rs/m_enable", 32'(m_enable), 32'd0);
    check("rs/grant_id", 32'(grant_id), 32'd0);
    man_ready = 1'b1;
    bad = 0;
    repeat (3) begin @(negedge clk); if (rsp_valid != '0) bad++; end
    check("rs/no_rsp", 32'(bad), 32'd0);
    rst = 1'b1; man_mode = 1'b0;
    req_valid[3] = 1'b1;
    wait_grant("rs3", 4'b1000);
    req_valid[3] = 1'b0;
    wait_rsp("rs3", 4'b1000, 1'b0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Round-robin transaction arbiter that shares one `i2c_controller` master among `NREQ` independent requesters. It accepts single-byte read/write commands (7-bit address, data, rw), drives the controller's `addr`/`data_in`/`rw`/`enable` inputs, and tracks completion through `ready`. It returns the read byte, or the completion of a write, to the granted requester. It sits between on-chip clients and the `i2c_controller` instance; the controller's `i2c_sda`/`i2c_scl` pins are untouched.

## Interface
- `NREQ`, 4, number of requesters (2..8).
- `TIMEOUT`, 4096, watchdog limit in `clk` cycles (used only with `I2C_ARB_TIMEOUT_EN`).
- `clk`  in  1  system clock, shared with `i2c_controller`.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester command valid; held until accepted.
- `req_ready`  out  NREQ  one-cycle accept pulse, one-hot.
- `req_addr`  in  7*NREQ  packed 7-bit slave addresses; requester i uses bits [7i+6:7i].
- `req_data`  in  8*NREQ  packed write bytes.
- `req_rw`  in  NREQ  1 = read, 0 = write.
- `rsp_valid`  out  NREQ  one-cycle completion pulse to the granted requester.
- `rsp_data`  out  8  read byte; valid with `rsp_valid`.
- `rsp_err`  out  1  timeout flag; valid with `rsp_valid`.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  clog2(NREQ)  index of current/last grant.
- `m_addr`  out  7  to controller `addr`.
- `m_data_in`  out  8  to controller `data_in`.
- `m_rw`  out  1  to controller `rw`.
- `m_enable`  out  1  to controller `enable`.
- `m_data_out`  in  8  from controller `data_out`.
- `m_ready`  in  1  from controller `ready`; passed through a 2-flop synchronizer to give `ready_s`.

## Operation
- States: IDLE, ISSUE, WAIT_DONE, RESPOND.
- IDLE: if any `req_valid` and `ready_s`=1, select the winner by round-robin. The search starts at `(last_grant+1) mod NREQ`; after reset it starts at index 0. Latch the winner's addr/data/rw into `m_addr`/`m_data_in`/`m_rw`, set `grant_id`, pulse `req_ready[w]`, then go to ISSUE.
- ISSUE: `m_enable`=1. When `ready_s`=0 is sampled, go to WAIT_DONE with `m_enable`=0.
- WAIT_DONE: when `ready_s`=1 is sampled, capture `m_data_out` into `rsp_data` and go to RESPOND.
- RESPOND: `rsp_valid[grant_id]`=1 for one cycle, update `last_grant`=`grant_id`, return to IDLE.
- `m_addr`/`m_data_in`/`m_rw` stay stable from ISSUE entry until the next grant.
- `req_valid` dropped before acceptance: the request is withdrawn, with no side effects.
- `req_valid` from the granted requester during its own transaction: ignored until the next IDLE arbitration.
- `ready_s`=0 in IDLE (controller still busy): no grant, `req_ready` stays 0.
- `rsp_data` holds its value until the next capture; for write transactions it is the value of `m_data_out` at completion, and clients must ignore it.

## Timing
- Reset values (async assert): state IDLE, all `req_ready`/`rsp_valid` 0, `rsp_err` 0, `rsp_data` 0, `busy` 0, `grant_id` 0, `m_enable` 0, `m_addr`/`m_data_in`/`m_rw` 0, synchronizer flops 1 (idle controller).
- Reset mid-transaction: `m_enable` drops immediately and the transaction is abandoned. No `rsp_valid` is issued.
- Grant: `req_valid` high at edge N with IDLE and `ready_s`=1 gives `req_ready` and `m_enable` high from N+1.
- Drop: `m_enable` falls the cycle after `ready_s`=0 is sampled, so the minimum enable width is 3 cycles because of the synchronizer.
- Completion: `rsp_valid` is asserted the cycle after `ready_s`=1 is sampled in WAIT_DONE. The next grant is possible at the earliest in the cycle after RESPOND.
- Two simultaneous requests are served back-to-back in round-robin order. No requester waits more than NREQ-1 transactions.

## Configuration
- `I2C_ARB_TIMEOUT_EN` defined:
  - A 13-bit (≥clog2(TIMEOUT)+1) cycle counter clears on ISSUE entry and counts in ISSUE and WAIT_DONE.
  - On reaching `TIMEOUT`, `m_enable` goes to 0 and the block enters RESPOND with `rsp_err`=1 and `rsp_data` unchanged.
  - `rsp_err` is 0 on normal completion.
- `I2C_ARB_TIMEOUT_EN` undefined: no counter exists, `rsp_err` is tied to 0, and the block waits indefinitely.

## Test plan
- Single write: requester 0, addr 7'h2A, data 8'hAA, rw 0, with the `i2c_controller` and `i2c_slave_controller` instances connected -> `req_ready[0]` 1 cycle later, `m_addr`=7'h2A, one `rsp_valid[0]` pulse, `rsp_err`=0.
- Read: requester 2, addr 7'h2A, rw 1 -> `rsp_valid[2]` with `rsp_data` equal to the byte returned by the slave model.
- Contention: requesters 0, 1, 3 assert together at reset exit -> grants in order 0, 1, 3. Re-asserting 0 after its response while 3 is waiting is served after 3.
- Busy controller: hold `m_ready`=0 in IDLE with `req_valid[1]`=1 -> no `req_ready` until `m_ready` rises. Grant is 3 cycles after the rise.
- Reset mid-WAIT_DONE: deassert `rst` -> `m_enable`=0, `busy`=0 asynchronously, no `rsp_valid`. A new request after reset is granted normally.
- Timeout (macro defined, `TIMEOUT`=64): stub holds `m_ready`=1 forever -> `rsp_valid` with `rsp_err`=1 at 64 cycles after ISSUE entry. Without the macro: `busy` stays 1.
